// File: rtl/uart_rx_dev.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_dev: bus-mapped 8N1 UART receiver with receive FIFO and IRQ      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_rx_dev #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned FifoDepth      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        uart_rx_i,
  output logic        uart_rx_irq_o
);

  localparam int unsigned c_clks_per_bit = ClockFrequency / BaudRate;
  localparam int unsigned c_cnt_w        = $clog2(c_clks_per_bit);
  localparam int unsigned c_ptr_w        = $clog2(FifoDepth) + 1;
  localparam int unsigned c_idx_w        = c_ptr_w - 1;

  localparam logic [c_cnt_w-1:0] c_bit_end  = c_cnt_w'(c_clks_per_bit - 1);
  localparam logic [c_cnt_w-1:0] c_half_end = c_cnt_w'(c_clks_per_bit / 2 - 1);
  localparam logic [c_ptr_w-1:0] c_full_xor = {1'b1, {c_idx_w{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic               r_rx_meta;
  logic               r_rx_s;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_clk_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [2:0]         r_bit_idx;
  logic [2:0]         w_bit_nxt;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nxt;
  logic               w_stop_ok;
  logic               w_stop_bad;

  logic [7:0]         r_mem [FifoDepth];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic               w_empty;
  logic               w_full;
  logic [7:0]         w_head;
  logic               w_push;
  logic               w_pop;

  logic               r_overrun;
  logic               r_frame_err;
  logic               r_irq_en;
  logic               r_rvalid;
  logic [31:0]        r_rdata;
  logic [31:0]        w_rdata_nxt;

  logic               w_rd;
  logic               w_wr;
  logic [1:0]         w_addr;
  logic               w_ovr_set;
  logic               w_ovr_clr;
  logic               w_fe_clr;
  logic               w_unused_bits;

  assign w_unused_bits = ^{device_be_i, device_addr_i[31:4], device_addr_i[1:0],
                           device_wdata_i[31:4], device_wdata_i[1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx_i;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_clk_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        // Sampling mid start bit rejects glitches shorter than half a bit.
        if (r_clk_cnt == c_half_end) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_bit_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == c_bit_end) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = r_rx_s;
          w_bit_nxt              = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_clk_cnt == c_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_stop_ok   = r_rx_s;
          w_stop_bad  = ~r_rx_s;
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rd   = device_req_i & ~device_we_i;
  assign w_wr   = device_req_i & device_we_i;
  assign w_addr = device_addr_i[3:2];

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = ((r_wptr ^ r_rptr) == c_full_xor);
  assign w_head  = r_mem[r_rptr[c_idx_w-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign w_pop     = w_rd & (w_addr == 2'd0) & ~w_empty;
  assign w_push    = w_stop_ok & (~w_full | w_pop);
  assign w_ovr_set = w_stop_ok & w_full & ~w_pop;
  assign w_ovr_clr = w_wr & (w_addr == 2'd1) & device_wdata_i[2];
  assign w_fe_clr  = w_wr & (w_addr == 2'd1) & device_wdata_i[3];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr[c_idx_w-1:0]] <= r_shift;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq_en    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_overrun   <= w_ovr_set | (r_overrun & ~w_ovr_clr);
      r_frame_err <= w_stop_bad | (r_frame_err & ~w_fe_clr);
      if (w_wr && (w_addr == 2'd2)) begin
        r_irq_en <= device_wdata_i[0];
      end
    end
  end

  always_comb begin
    w_rdata_nxt = '0;
    case (w_addr)
      2'd0:    w_rdata_nxt = w_empty ? 32'h8000_0000 : {24'b0, w_head};
      2'd1:    w_rdata_nxt = {28'b0, r_frame_err, r_overrun, w_full, ~w_empty};
      2'd2:    w_rdata_nxt = {31'b0, r_irq_en};
      default: w_rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= device_req_i;
      if (w_rd) begin
        r_rdata <= w_rdata_nxt;
      end
    end
  end

  assign device_rvalid_o = r_rvalid;
  assign device_rdata_o  = r_rdata;
  assign uart_rx_irq_o   = r_irq_en & ~w_empty;

endmodule
`default_nettype wire
